// File: rtl/hpi_access_sequencer_if.sv
// rtl/hpi_access_sequencer_if.sv - host request/response and HPI pad signals of the access sequencer
interface hpi_access_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             iREQ;
    logic             iWE;
    logic             iBLOCK;
    logic [1:0]       iREG;
    logic [15:0]      iMADDR;
    logic [LEN_W-1:0] iLEN;
    logic [15:0]      iWDATA;
    logic             oWNEXT;
    logic [15:0]      oRDATA;
    logic             oRVALID;
    logic             oBUSY;
    logic             oDONE;
    logic [1:0]       oHPI_ADDR;
    logic             oHPI_CS_N;
    logic             oHPI_RD_N;
    logic             oHPI_WR_N;
    logic [15:0]      oHPI_DOUT;
    logic             oHPI_DOE;
    logic [15:0]      iHPI_DIN;

    modport slave (
        input  iREQ, iWE, iBLOCK, iREG, iMADDR, iLEN, iWDATA, iHPI_DIN,
        output oWNEXT, oRDATA, oRVALID, oBUSY, oDONE,
               oHPI_ADDR, oHPI_CS_N, oHPI_RD_N, oHPI_WR_N, oHPI_DOUT, oHPI_DOE
    );

    modport master (
        output iREQ, iWE, iBLOCK, iREG, iMADDR, iLEN, iWDATA, iHPI_DIN,
        input  oWNEXT, oRDATA, oRVALID, oBUSY, oDONE,
               oHPI_ADDR, oHPI_CS_N, oHPI_RD_N, oHPI_WR_N, oHPI_DOUT, oHPI_DOE
    );
endinterface

// File: rtl/hpi_access_sequencer.sv
// rtl/hpi_access_sequencer.sv - timed CS/RD/WR sequencer for single and block HPI accesses
module hpi_access_sequencer #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1,
    parameter int RECOV_CYC  = 2,
    parameter int LEN_W      = 8
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    hpi_access_sequencer_if.slave bus
);
    localparam int CW = 8;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOV} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic             blk_q, blk_d, cmd_we_q, cmd_we_d, acc_we_q, acc_we_d;
    logic [1:0]       addr_q, addr_d;
    logic [15:0]      dout_q, dout_d, rdata_q, rdata_d;
    logic             cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, doe_q, doe_d;
    logic             busy_q, busy_d, done_q, done_d, rvalid_q, rvalid_d, wnext_q, wnext_d;
    logic             last, active_d;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        words_d  = words_q;
        blk_d    = blk_q;
        cmd_we_d = cmd_we_q;
        acc_we_d = acc_we_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        rvalid_d = 1'b0;
        last     = (cyc_q == '0);
        if (state_q != S_IDLE && !last) cyc_d = cyc_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.iREQ) begin
                    state_d  = S_SETUP;
                    cyc_d    = CW'(SETUP_CYC - 1);
                    blk_d    = bus.iBLOCK;
                    cmd_we_d = bus.iWE;
                    words_d  = bus.iBLOCK ? bus.iLEN : '0;
                    // a block transfer always opens with an ADDRESS-register write
                    acc_we_d = bus.iBLOCK | bus.iWE;
                    addr_d   = bus.iBLOCK ? 2'd2 : bus.iREG;
                    dout_d   = bus.iBLOCK ? bus.iMADDR : bus.iWDATA;
                end
            end
            S_SETUP: if (last) begin
                state_d = S_STROBE;
                cyc_d   = CW'(STROBE_CYC - 1);
            end
            S_STROBE: if (last) begin
                state_d = S_HOLD;
                cyc_d   = CW'(HOLD_CYC - 1);
                if (!acc_we_q) begin
                    rdata_d  = bus.iHPI_DIN;
                    rvalid_d = 1'b1;
                end
            end
            S_HOLD: if (last) begin
                state_d = S_RECOV;
                cyc_d   = CW'(RECOV_CYC - 1);
            end
            S_RECOV: if (last) begin
                if (blk_q && words_q != '0) begin
                    state_d  = S_SETUP;
                    cyc_d    = CW'(SETUP_CYC - 1);
                    words_d  = words_q - 1'b1;
                    addr_d   = 2'd0;
                    acc_we_d = cmd_we_q;
                    if (cmd_we_q) dout_d = bus.iWDATA;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // pin levels are derived from the next state so every output leaves a flop
        active_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        cs_n_d   = !active_d;
        rd_n_d   = !(state_d == S_STROBE && !acc_we_d);
        wr_n_d   = !(state_d == S_STROBE && acc_we_d);
        doe_d    = active_d && acc_we_d;
        busy_d   = (state_d != S_IDLE);
        wnext_d  = (state_d == S_RECOV) && (cyc_d == '0) && blk_q && cmd_we_q && (words_q != '0);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            words_q  <= '0;
            blk_q    <= 1'b0;
            cmd_we_q <= 1'b0;
            acc_we_q <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            rdata_q  <= '0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            doe_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            wnext_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            words_q  <= words_d;
            blk_q    <= blk_d;
            cmd_we_q <= cmd_we_d;
            acc_we_q <= acc_we_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            rdata_q  <= rdata_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            doe_q    <= doe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
            wnext_q  <= wnext_d;
        end
    end

    assign bus.oWNEXT    = wnext_q;
    assign bus.oRDATA    = rdata_q;
    assign bus.oRVALID   = rvalid_q;
    assign bus.oBUSY     = busy_q;
    assign bus.oDONE     = done_q;
    assign bus.oHPI_ADDR = addr_q;
    assign bus.oHPI_CS_N = cs_n_q;
    assign bus.oHPI_RD_N = rd_n_q;
    assign bus.oHPI_WR_N = wr_n_q;
    assign bus.oHPI_DOUT = dout_q;
    assign bus.oHPI_DOE  = doe_q;
endmodule
